// File: rtl/ofm_writeback_pkg.sv
// rtl/ofm_writeback_pkg.sv - shared state encoding, geometry helpers and lane ReLU/saturate.
package ofm_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Column tiles per OFM row.
  function automatic int calc_tpl(input int ofm_size, input int systolic_size);
    return (ofm_size + systolic_size - 1) / systolic_size;
  endfunction

  function automatic int calc_addr_w(input int no_filter, input int ofm_size, input int systolic_size);
    return $clog2(no_filter * ofm_size * calc_tpl(ofm_size, systolic_size));
  endfunction

  // Works on a 64-bit signed carrier so any PSUM_W/OUT_W pair up to 63 bits can share it.
  function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v, input int out_w,
                                                  input logic relu);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] r;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    r = v;
    if (relu && (r < 64'sd0)) r = 64'sd0;
    if (r > max_v) r = max_v;
    else if (r < min_v) r = min_v;
    return r;
  endfunction

endpackage

// File: rtl/ofm_lane_sat.sv
// rtl/ofm_lane_sat.sv - combinational PSUM_W to OUT_W ReLU/saturate for one lane.
module ofm_lane_sat
  import ofm_writeback_pkg::*;
#(
  parameter int PSUM_W  = 32,
  parameter int OUT_W   = 16,
  parameter bit RELU_EN = 1'b1
) (
  input  logic [PSUM_W-1:0] psum,
  output logic [OUT_W-1:0]  q
);

  logic signed [63:0] wide;
  logic signed [63:0] res;

  always_comb begin
    wide = {{(64-PSUM_W){psum[PSUM_W-1]}}, psum};
    res  = relu_sat(wide, OUT_W, RELU_EN);
    q    = OUT_W'(res);
  end

endmodule

// File: rtl/ofm_writeback.sv
// rtl/ofm_writeback.sv - OFM write-back: frame sequencing, address generation, lane processing.
module ofm_writeback
  import ofm_writeback_pkg::*;
#(
  parameter int NO_FILTER     = 16,
  parameter int OFM_SIZE      = 32,
  parameter int SYSTOLIC_SIZE = 16,
  parameter int PSUM_W        = 32,
  parameter int OUT_W         = 16,
  parameter bit RELU_EN       = 1'b1,
  localparam int TPL          = calc_tpl(OFM_SIZE, SYSTOLIC_SIZE),
  localparam int ADDR_W       = calc_addr_w(NO_FILTER, OFM_SIZE, SYSTOLIC_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [4:0]                      wgt_size,
  input  logic                            write_ofm_en,
  input  logic [SYSTOLIC_SIZE*PSUM_W-1:0] pe_data,
  output logic                            ofm_wr_en,
  output logic [ADDR_W-1:0]               ofm_addr,
  output logic [SYSTOLIC_SIZE*OUT_W-1:0]  ofm_wr_data,
  output logic [SYSTOLIC_SIZE-1:0]        ofm_wr_mask,
  output logic                            frame_done,
  output logic                            err
);

  state_t                           state_q, state_d;
  logic [4:0]                       wgs_q, wgs_d;
  logic [31:0]                      k_q, k_d, tile_q, tile_d, row_q, row_d, fbase_q, fbase_d;
  logic                             err_q, err_d, wr_en_q, wr_en_d, done_q, done_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [SYSTOLIC_SIZE*OUT_W-1:0]   data_q, data_d;
  logic [SYSTOLIC_SIZE-1:0]         mask_q, mask_d;
  logic [OUT_W-1:0]                 lane_sat [SYSTOLIC_SIZE];
  logic                             legal, last;
  logic [31:0]                      f, wgs_w;

  for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
    ofm_lane_sat #(.PSUM_W(PSUM_W), .OUT_W(OUT_W), .RELU_EN(RELU_EN)) u_sat (
      .psum(pe_data[i*PSUM_W +: PSUM_W]),
      .q   (lane_sat[i])
    );
  end

  always_comb begin
    state_d = state_q;
    wgs_d   = wgs_q;
    k_d     = k_q;
    tile_d  = tile_q;
    row_d   = row_q;
    fbase_d = fbase_q;
    err_d   = err_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;

    legal = (wgt_size != 5'd0) && (32'(wgt_size) <= SYSTOLIC_SIZE);
    wgs_w = 32'(wgs_q);
    f     = fbase_q + k_q;
    last  = (row_q == OFM_SIZE - 1) && (tile_q == TPL - 1) && (k_q == wgs_w - 1) &&
            (fbase_q + wgs_w >= NO_FILTER);

    case (state_q)
      ST_ACTIVE: begin
        if (start) begin
          k_d = '0; tile_d = '0; row_d = '0; fbase_d = '0;
          if (legal) begin
            wgs_d = wgt_size;
            err_d = 1'b0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (write_ofm_en) begin
          // Filters past NO_FILTER still step the sequence but never reach memory.
          wr_en_d = (f < NO_FILTER);
          addr_d  = ADDR_W'(f * 32'(OFM_SIZE * TPL) + row_q * 32'(TPL) + tile_q);
          for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            mask_d[i] = (tile_q * SYSTOLIC_SIZE + i) < OFM_SIZE;
            data_d[i*OUT_W +: OUT_W] = mask_d[i] ? lane_sat[i] : '0;
          end
          if (k_q == wgs_w - 1) begin
            k_d = '0;
            if (tile_q == TPL - 1) begin
              tile_d = '0;
              if (row_q == OFM_SIZE - 1) begin
                row_d   = '0;
                fbase_d = fbase_q + wgs_w;
              end else begin
                row_d = row_q + 1;
              end
            end else begin
              tile_d = tile_q + 1;
            end
          end else begin
            k_d = k_q + 1;
          end
          if (last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (write_ofm_en) err_d = 1'b1;
        if (start) begin
          k_d = '0; tile_d = '0; row_d = '0; fbase_d = '0;
          if (legal) begin
            state_d = ST_ACTIVE;
            wgs_d   = wgt_size;
            // A vector arriving with start is dropped and still flagged.
            err_d   = write_ofm_en;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wgs_q   <= '0;
      k_q     <= '0;
      tile_q  <= '0;
      row_q   <= '0;
      fbase_q <= '0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      wgs_q   <= wgs_d;
      k_q     <= k_d;
      tile_q  <= tile_d;
      row_q   <= row_d;
      fbase_q <= fbase_d;
      err_q   <= err_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign ofm_wr_en   = wr_en_q;
  assign ofm_addr    = addr_q;
  assign ofm_wr_data = data_q;
  assign ofm_wr_mask = mask_q;
  assign frame_done  = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// tb/tb_ofm_writeback.sv - scoreboard bench for ofm_writeback (default and OFM_SIZE=20/no-ReLU builds).
module tb_ofm_writeback;

  localparam int NF = 16;

  typedef struct {
    logic [9:0]   addr;
    logic [255:0] data;
    logic [15:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_a, wen_a, wr_a, done_a, err_a;
  logic [4:0]   wgt_a;
  logic [511:0] pe_a;
  logic [9:0]   addr_a;
  logic [255:0] data_a;
  logic [15:0]  mask_a;
  logic         start_b, wen_b, wr_b, done_b, err_b;
  logic [4:0]   wgt_b;
  logic [511:0] pe_b;
  logic [9:0]   addr_b;
  logic [255:0] data_b;
  logic [15:0]  mask_b;

  ofm_writeback #(.NO_FILTER(16), .OFM_SIZE(32), .SYSTOLIC_SIZE(16), .PSUM_W(32), .OUT_W(16),
                  .RELU_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .wgt_size(wgt_a), .write_ofm_en(wen_a),
    .pe_data(pe_a), .ofm_wr_en(wr_a), .ofm_addr(addr_a), .ofm_wr_data(data_a),
    .ofm_wr_mask(mask_a), .frame_done(done_a), .err(err_a)
  );

  ofm_writeback #(.NO_FILTER(16), .OFM_SIZE(20), .SYSTOLIC_SIZE(16), .PSUM_W(32), .OUT_W(16),
                  .RELU_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .wgt_size(wgt_b), .write_ofm_en(wen_b),
    .pe_data(pe_b), .ofm_wr_en(wr_b), .ofm_addr(addr_b), .ofm_wr_data(data_b),
    .ofm_wr_mask(mask_b), .frame_done(done_b), .err(err_b)
  );

  int   checks = 0;
  int   errors = 0;
  int   wr_cnt_a = 0;
  int   wr_cnt_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic [15:0] tile1_mask_b = 16'hxxxx;

  always @(negedge clk) begin
    if (!rst && wr_a) begin
      wr_cnt_a++;
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a_unexpected got addr=%0d required no write", addr_a);
      end else begin
        e_a = q_a.pop_front();
        if (addr_a !== e_a.addr || data_a !== e_a.data || mask_a !== e_a.mask) begin
          errors++;
          $display("FAIL wr_a_word got addr=%0d mask=%h data=%h required addr=%0d mask=%h data=%h",
                   addr_a, mask_a, data_a, e_a.addr, e_a.mask, e_a.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_b) begin
      wr_cnt_b++;
      checks++;
      if (addr_b[0]) tile1_mask_b = mask_b;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b_unexpected got addr=%0d required no write", addr_b);
      end else begin
        e_b = q_b.pop_front();
        if (addr_b !== e_b.addr || data_b !== e_b.data || mask_b !== e_b.mask) begin
          errors++;
          $display("FAIL wr_b_word got addr=%0d mask=%h data=%h required addr=%0d mask=%h data=%h",
                   addr_b, mask_b, data_b, e_b.addr, e_b.mask, e_b.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_lane(input logic signed [31:0] v, input bit relu);
    if (relu && v < 0) return 16'h0000;
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [31:0] rand_psum();
    int x;
    case ($urandom_range(0, 3))
      0: x = int'($urandom);
      1: x = int'($urandom_range(0, 80000)) - 40000;
      2: x = int'($urandom_range(0, 600)) - 300;
      default: begin
        case ($urandom_range(0, 3))
          0: x = 32767;
          1: x = 32768;
          2: x = -32768;
          default: x = -32769;
        endcase
      end
    endcase
    return x;
  endfunction

  task automatic set_in(input bit sel, input logic s, input logic [4:0] w, input logic en,
                        input logic [511:0] pe);
    if (sel) begin
      start_b = s; wgt_b = w; wen_b = en; pe_b = pe;
    end else begin
      start_a = s; wgt_a = w; wen_a = en; pe_a = pe;
    end
  endtask

  task automatic idle_cycle(input bit sel);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 5'd0, 1'b0, '0);
  endtask

  task automatic drive_vec(input bit sel, input logic [511:0] pe);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 5'd0, 1'b1, pe);
  endtask

  task automatic do_start(input bit sel, input logic [4:0] w);
    @(posedge clk); #1;
    set_in(sel, 1'b1, w, 1'b0, '0);
    idle_cycle(sel);
  endtask

  // nvec == 0 runs the whole frame and checks its completion; otherwise stops after nvec vectors.
  task automatic run_frame(input bit sel, input int wgs, input int ofm, input bit relu,
                           input int nvec, input bit gaps);
    int tpl, groups, n, f;
    bit stop;
    logic [511:0] pe;
    logic [255:0] d;
    logic [15:0] m;
    logic [31:0] v;
    exp_t e;
    tpl = (ofm + 15) / 16;
    groups = (NF + wgs - 1) / wgs;
    n = 0;
    stop = 1'b0;
    do_start(sel, 5'(wgs));
    for (int g = 0; g < groups; g++)
      for (int r = 0; r < ofm; r++)
        for (int t = 0; t < tpl; t++)
          for (int k = 0; k < wgs; k++) begin
            if (nvec != 0 && n == nvec) stop = 1'b1;
            if (!stop) begin
              f = g * wgs + k;
              for (int i = 0; i < 16; i++) begin
                v = rand_psum();
                pe[i*32 +: 32] = v;
                m[i] = (t * 16 + i) < ofm;
                d[i*16 +: 16] = m[i] ? exp_lane(v, relu) : 16'h0000;
              end
              if (f < NF) begin
                e.addr = 10'(f * ofm * tpl + r * tpl + t);
                e.data = d;
                e.mask = m;
                if (sel) q_b.push_back(e);
                else q_a.push_back(e);
              end
              drive_vec(sel, pe);
              n++;
              if (gaps && $urandom_range(0, 7) == 0) idle_cycle(sel);
            end
          end
    idle_cycle(sel);
    @(negedge clk);
    if (nvec == 0) begin
      checks++;
      if ((sel ? done_b : done_a) !== 1'b1) begin
        errors++;
        $display("FAIL frame_done_last sel=%0d wgs=%0d got %b required 1", sel, wgs,
                 sel ? done_b : done_a);
      end
      checks++;
      if ((sel ? err_b : err_a) !== 1'b0) begin
        errors++;
        $display("FAIL frame_err sel=%0d wgs=%0d got %b required 0", sel, wgs, sel ? err_b : err_a);
      end
    end
    @(negedge clk);
    if (nvec == 0) begin
      checks++;
      if ((sel ? done_b : done_a) !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_pulse sel=%0d got %b required 0", sel, sel ? done_b : done_a);
      end
    end
    checks++;
    if ((sel ? q_b.size() : q_a.size()) != 0) begin
      errors++;
      $display("FAIL missing_writes sel=%0d got %0d outstanding required 0", sel,
               sel ? q_b.size() : q_a.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wr_a, addr_a, data_a, mask_a, done_a, err_a} !== '0 ||
        {wr_b, addr_b, data_b, mask_b, done_b, err_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got a_wr=%b a_addr=%0d a_err=%b b_wr=%b b_addr=%0d required all 0",
               wr_a, addr_a, err_a, wr_b, addr_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_a !== 1'b0 || wr_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_write got a=%b b=%b required 0", wr_a, wr_b);
    end
  endtask

  task automatic test_lane_sat(input bit sel);
    logic [511:0] pe;
    logic [255:0] d;
    logic [31:0] pat [4];
    logic [15:0] res [4];
    exp_t e;
    pat[0] = 32'h0001_0000; pat[1] = 32'hFFFF_FFFB; pat[2] = 32'h0000_7FFF; pat[3] = 32'hFFFF_7000;
    if (sel) begin
      res[0] = 16'h7FFF; res[1] = 16'hFFFB; res[2] = 16'h7FFF; res[3] = 16'h8000;
    end else begin
      res[0] = 16'h7FFF; res[1] = 16'h0000; res[2] = 16'h7FFF; res[3] = 16'h0000;
    end
    for (int i = 0; i < 16; i++) begin
      pe[i*32 +: 32] = pat[i%4];
      d[i*16 +: 16]  = res[i%4];
    end
    e.addr = 10'd0; e.data = d; e.mask = 16'hFFFF;
    if (sel) q_b.push_back(e);
    else q_a.push_back(e);
    do_start(sel, 5'd16);
    drive_vec(sel, pe);
    idle_cycle(sel);
    @(negedge clk);
    checks++;
    if ((sel ? wr_b : wr_a) !== 1'b1 || (sel ? data_b : data_a) !== d) begin
      errors++;
      $display("FAIL lane_sat sel=%0d got wr=%b data=%h required wr=1 data=%h", sel,
               sel ? wr_b : wr_a, sel ? data_b : data_a, d);
    end
  endtask

  task automatic test_full_frame();
    int c0;
    c0 = wr_cnt_a;
    run_frame(1'b0, 16, 32, 1'b1, 0, 1'b1);
    checks++;
    if (wr_cnt_a - c0 != 1024) begin
      errors++;
      $display("FAIL full_frame_writes got %0d required 1024", wr_cnt_a - c0);
    end
  endtask

  task automatic test_suppress();
    int c0;
    c0 = wr_cnt_a;
    run_frame(1'b0, 5, 32, 1'b1, 0, 1'b1);
    checks++;
    if (wr_cnt_a - c0 != 1024) begin
      errors++;
      $display("FAIL suppress_writes got %0d required 1024", wr_cnt_a - c0);
    end
  endtask

  task automatic test_mask();
    run_frame(1'b1, 16, 20, 1'b0, 0, 1'b0);
    checks++;
    if (tile1_mask_b !== 16'h000F) begin
      errors++;
      $display("FAIL tile1_mask got %h required 000f", tile1_mask_b);
    end
  endtask

  task automatic test_idle_err();
    int c0;
    c0 = wr_cnt_a;
    drive_vec(1'b0, {16{32'h0000_1234}});
    idle_cycle(1'b0);
    @(negedge clk);
    checks++;
    if (err_a !== 1'b1 || wr_a !== 1'b0 || wr_cnt_a != c0) begin
      errors++;
      $display("FAIL idle_write got err=%b wr=%b writes=%0d required err=1 wr=0 writes=%0d",
               err_a, wr_a, wr_cnt_a, c0);
    end
    do_start(1'b0, 5'd16);
    @(negedge clk);
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_err got %b required 0", err_a);
    end
    do_start(1'b0, 5'd17);
    @(negedge clk);
    checks++;
    if (err_a !== 1'b1) begin
      errors++;
      $display("FAIL illegal_start_17 got err=%b required 1", err_a);
    end
    do_start(1'b0, 5'd1);
    do_start(1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (err_a !== 1'b1) begin
      errors++;
      $display("FAIL illegal_start_0 got err=%b required 1", err_a);
    end
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 5'd16, 1'b1, {16{32'h0000_0042}});
    idle_cycle(1'b0);
    @(negedge clk);
    checks++;
    if (err_a !== 1'b1 || wr_a !== 1'b0) begin
      errors++;
      $display("FAIL start_with_vector got err=%b wr=%b required err=1 wr=0", err_a, wr_a);
    end
  endtask

  task automatic test_reset_midframe();
    run_frame(1'b0, 16, 32, 1'b1, 300, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_a !== 1'b0 || err_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset got wr=%b err=%b done=%b required 0 0 0", wr_a, err_a, done_a);
    end
    run_frame(1'b0, 16, 32, 1'b1, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 5'd0, 1'b0, '0);
    set_in(1'b1, 1'b0, 5'd0, 1'b0, '0);
    test_reset();
    test_lane_sat(1'b0);
    test_lane_sat(1'b1);
    test_full_frame();
    test_suppress();
    test_mask();
    test_idle_err();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
